// File: rtl/unstrip_pkg.sv
// Shared constants, state encoding and symbol helpers for the byte un-striping controller.
package unstrip_pkg;

    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] SKP = 8'h1C;
    localparam logic [7:0] IDL = 8'h7C;
    localparam logic [7:0] STP = 8'hFB;
    localparam logic [7:0] SDP = 8'h5C;
    localparam logic [7:0] END = 8'hFD;
    localparam logic [7:0] EDB = 8'hFE;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAlign = 2'd1,
        StRun   = 2'd2
    } state_e;

    function automatic logic is_known_k(input logic [7:0] sym);
        return sym inside {COM, SKP, IDL, STP, SDP, END, EDB};
    endfunction

    // Highest active lane index for a lane-count code (1, 2 or 4 lanes).
    function automatic logic [1:0] last_lane(input logic [1:0] cfg);
        case (cfg)
            2'd0:    return 2'd0;
            2'd1:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/unstrip_ctrl_if.sv
// Lane inputs and un-striped byte stream between the lane registers, controller and parser.
interface unstrip_ctrl_if #(
    parameter int unsigned BITS = 8,
    parameter int unsigned ERRW = 8
);
    logic            enable;
    logic [1:0]      lane_cfg;
    logic [BITS-1:0] lane0;
    logic [BITS-1:0] lane1;
    logic [BITS-1:0] lane2;
    logic [BITS-1:0] lane3;
    logic            dk_0;
    logic            dk_1;
    logic            dk_2;
    logic            dk_3;
    logic [1:0]      lane_sel;
    logic [BITS-1:0] d;
    logic            dk;
    logic            d_valid;
    logic            link_up;
    logic            pkt_active;
    logic            frame_err;
    logic [ERRW-1:0] err_cnt;

    modport master (
        output enable, lane_cfg, lane0, lane1, lane2, lane3, dk_0, dk_1, dk_2, dk_3,
        input  lane_sel, d, dk, d_valid, link_up, pkt_active, frame_err, err_cnt
    );

    modport slave (
        input  enable, lane_cfg, lane0, lane1, lane2, lane3, dk_0, dk_1, dk_2, dk_3,
        output lane_sel, d, dk, d_valid, link_up, pkt_active, frame_err, err_cnt
    );
endinterface

// File: rtl/unstrip_frame_chk.sv
// Packet framing tracker: PKT_ACTIVE, one-cycle FRAME_ERR pulse and saturating error count.
module unstrip_frame_chk
    import unstrip_pkg::*;
#(
    parameter int unsigned BITS = 8,
    parameter int unsigned ERRW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            eval,
    input  logic            skew,
    input  logic [BITS-1:0] sym,
    input  logic            k,
    output logic            pkt_active,
    output logic            frame_err,
    output logic [ERRW-1:0] err_cnt
);

    logic            open_q, open_d;
    logic            pkt_q, pkt_d;
    logic            err_q, err_d;
    logic [ERRW-1:0] cnt_q, cnt_d;
    logic            is_start, is_stop, bad_k;

    assign is_start = k && (sym == BITS'(STP) || sym == BITS'(SDP));
    assign is_stop  = k && (sym == BITS'(END) || sym == BITS'(EDB));
    assign bad_k    = k && !is_known_k(8'(sym));

    always_comb begin
        open_d = 1'b0;
        pkt_d  = 1'b0;
        err_d  = 1'b0;
        cnt_d  = cnt_q;
        if (eval) begin
            err_d = skew | bad_k | (is_start && open_q) | (is_stop && !open_q);
            if (!skew) begin
                open_d = open_q;
                if (is_start && !open_q) begin
                    open_d = 1'b1;
                end else if (is_stop && open_q) begin
                    open_d = 1'b0;
                end
                // An END byte still reports active; the frame closes on the next byte.
                pkt_d = open_q | open_d;
            end
        end
        if (err_d && cnt_q != '1) begin
            cnt_d = cnt_q + ERRW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            open_q <= 1'b0;
            pkt_q  <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            open_q <= open_d;
            pkt_q  <= pkt_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pkt_active = pkt_q;
    assign frame_err  = err_q;
    assign err_cnt    = cnt_q;

endmodule

// File: rtl/unstrip_ctrl.sv
// Lane alignment FSM, round-robin lane select and byte mux feeding the frame checker.
module unstrip_ctrl
    import unstrip_pkg::*;
#(
    parameter int unsigned LANES = 4,
    parameter int unsigned BITS  = 8,
    parameter int unsigned ERRW  = 8
) (
    input logic           clk,
    input logic           reset,
    unstrip_ctrl_if.slave bus
);

    state_e          state_q, state_d;
    logic [1:0]      sel_q, sel_d;
    logic [1:0]      last_q, last_d;
    logic [BITS-1:0] lane_b [LANES];
    logic [LANES-1:0] lane_k, com_hit, active;
    logic            all_com, any_com, skew, run_en;
    logic [BITS-1:0] sel_byte, d_q, d_d;
    logic            sel_k, dk_q, dk_d, dv_q, dv_d;
    logic            pkt_active, frame_err;
    logic [ERRW-1:0] err_cnt;

    always_comb begin
        lane_b[0] = bus.lane0;
        lane_b[1] = bus.lane1;
        lane_b[2] = bus.lane2;
        lane_b[3] = bus.lane3;
        lane_k    = {bus.dk_3, bus.dk_2, bus.dk_1, bus.dk_0};
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            com_hit[i] = lane_k[i] && (lane_b[i] == BITS'(COM));
            active[i]  = (i <= int'(last_q));
        end
    end

    assign all_com  = &(com_hit | ~active);
    assign any_com  = |(com_hit & active);
    assign run_en   = bus.enable && (state_q == StRun);
    assign sel_byte = lane_b[sel_q];
    assign sel_k    = lane_k[sel_q];
    // Lanes drifted apart: COM showed up on only some lanes at a lane-0 boundary.
    assign skew     = run_en && (sel_q == 2'd0) && any_com && !all_com;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                last_d  = last_lane(bus.lane_cfg);
                sel_d   = '0;
                state_d = StAlign;
            end
            StAlign: begin
                sel_d = '0;
                if (all_com) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (skew) begin
                    state_d = StAlign;
                    sel_d   = '0;
                end else begin
                    sel_d = (sel_q == last_q) ? 2'd0 : sel_q + 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (!bus.enable) begin
            state_d = StIdle;
            sel_d   = '0;
        end
    end

    always_comb begin
        d_d  = '0;
        dk_d = 1'b0;
        dv_d = 1'b0;
        if (run_en) begin
            d_d  = sel_byte;
            dk_d = sel_k;
            dv_d = !(sel_k && (sel_byte == BITS'(IDL) || sel_byte == BITS'(SKP) ||
                               sel_byte == BITS'(COM)));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            sel_q   <= '0;
            last_q  <= 2'd3;
            d_q     <= '0;
            dk_q    <= 1'b0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            d_q     <= d_d;
            dk_q    <= dk_d;
            dv_q    <= dv_d;
        end
    end

    unstrip_frame_chk #(
        .BITS(BITS),
        .ERRW(ERRW)
    ) u_frame_chk (
        .clk        (clk),
        .reset      (reset),
        .eval       (run_en),
        .skew       (skew),
        .sym        (sel_byte),
        .k          (sel_k),
        .pkt_active (pkt_active),
        .frame_err  (frame_err),
        .err_cnt    (err_cnt)
    );

    assign bus.lane_sel   = sel_q;
    assign bus.d          = d_q;
    assign bus.dk         = dk_q;
    assign bus.d_valid    = dv_q;
    assign bus.link_up    = (state_q == StRun);
    assign bus.pkt_active = pkt_active;
    assign bus.frame_err  = frame_err;
    assign bus.err_cnt    = err_cnt;

endmodule

// File: tb/tb_unstrip_ctrl.sv
// Directed scenarios plus randomized traffic checked against a behavioural lane/frame model.
module tb_unstrip_ctrl;

    localparam logic [7:0] K_COM = 8'hBC, K_SKP = 8'h1C, K_IDL = 8'h7C, K_STP = 8'hFB;
    localparam logic [7:0] K_SDP = 8'h5C, K_END = 8'hFD, K_EDB = 8'hFE;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    unstrip_ctrl_if #(.BITS(8), .ERRW(8)) bus ();

    unstrip_ctrl #(.LANES(4), .BITS(8), .ERRW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // Model: 0 = off, 1 = hunting for COM, 2 = locked.
    int         m_mode = 0, m_n = 4, m_pos = 0;
    bit         m_open = 0;
    logic [7:0] e_d = 0;
    bit         e_dk = 0, e_dv = 0, e_pkt = 0, e_ferr = 0, e_link = 0;
    int         e_sel = 0, e_cnt = 0;

    function automatic int cfg_lanes(logic [1:0] c);
        return (c == 2'd0) ? 1 : (c == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [7:0] lane_byte(int i);
        case (i)
            0: return bus.lane0;
            1: return bus.lane1;
            2: return bus.lane2;
            default: return bus.lane3;
        endcase
    endfunction

    function automatic bit lane_kf(int i);
        case (i)
            0: return bus.dk_0;
            1: return bus.dk_1;
            2: return bus.dk_2;
            default: return bus.dk_3;
        endcase
    endfunction

    function automatic bit known(logic [7:0] b);
        logic [7:0] tbl [7];
        tbl = '{K_COM, K_SKP, K_IDL, K_STP, K_SDP, K_END, K_EDB};
        foreach (tbl[i]) if (tbl[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_edge();
        int coms;
        logic [7:0] b;
        bit k, err, start, stop, skew;
        coms = 0;
        for (int i = 0; i < m_n; i++) if (lane_kf(i) && lane_byte(i) == K_COM) coms++;
        e_d = 0; e_dk = 0; e_dv = 0; e_ferr = 0; e_pkt = 0;
        if (reset === 1'b1) begin
            m_mode = 0; m_n = 4; m_pos = 0; m_open = 0; e_cnt = 0;
        end else if (bus.enable !== 1'b1) begin
            if (m_mode == 0) m_n = cfg_lanes(bus.lane_cfg);
            m_mode = 0; m_pos = 0; m_open = 0;
        end else if (m_mode == 0) begin
            m_n = cfg_lanes(bus.lane_cfg);
            m_mode = 1;
        end else if (m_mode == 1) begin
            m_open = 0;
            if (coms == m_n) begin m_mode = 2; m_pos = 0; end
        end else begin
            b = lane_byte(m_pos);
            k = lane_kf(m_pos);
            e_d = b; e_dk = k;
            e_dv = !(k && (b == K_IDL || b == K_SKP || b == K_COM));
            start = 0; stop = 0; err = 0;
            if (k) begin
                if (b == K_STP || b == K_SDP) begin
                    if (m_open) err = 1; else start = 1;
                end else if (b == K_END || b == K_EDB) begin
                    if (!m_open) err = 1; else stop = 1;
                end else if (!known(b)) err = 1;
            end
            skew = (m_pos == 0) && coms > 0 && coms < m_n;
            if (skew) begin
                err = 1; m_mode = 1; m_pos = 0; m_open = 0; e_pkt = 0;
            end else begin
                e_pkt = m_open || start;
                m_open = (m_open || start) && !stop;
                m_pos = (m_pos + 1) % m_n;
            end
            e_ferr = err;
            if (err && e_cnt < 255) e_cnt++;
        end
        e_sel = m_pos;
        e_link = (m_mode == 2);
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(logic [7:0] b0, logic [7:0] b1, logic [7:0] b2, logic [7:0] b3,
                             logic [3:0] k);
        bus.lane0 = b0; bus.lane1 = b1; bus.lane2 = b2; bus.lane3 = b3;
        bus.dk_0 = k[0]; bus.dk_1 = k[1]; bus.dk_2 = k[2]; bus.dk_3 = k[3];
    endtask

    task automatic rand_sym(output logic [7:0] b, output logic k);
        int r;
        r = $urandom_range(0, 19);
        k = 1'b1;
        case (r)
            0: b = K_COM;
            1: b = K_SKP;
            2: b = K_IDL;
            3: b = K_STP;
            4: b = K_SDP;
            5: b = K_END;
            6: b = K_EDB;
            7: b = 8'($urandom);
            default: begin b = 8'($urandom); k = 1'b0; end
        endcase
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.enable = 1'b0;
        tick(); tick();
        checks++; if (bus.lane_sel !== 2'd0) begin failures++; $display("FAIL reset_sel: got %0h want 0", bus.lane_sel); end
        checks++; if (bus.d !== 8'h00) begin failures++; $display("FAIL reset_d: got %0h want 0", bus.d); end
        checks++; if (bus.dk !== 1'b0 || bus.d_valid !== 1'b0) begin failures++; $display("FAIL reset_dk_dv: got %0b%0b want 00", bus.dk, bus.d_valid); end
        checks++; if (bus.link_up !== 1'b0) begin failures++; $display("FAIL reset_link: got %0b want 0", bus.link_up); end
        checks++; if (bus.pkt_active !== 1'b0 || bus.frame_err !== 1'b0) begin failures++; $display("FAIL reset_pkt_err: got %0b%0b want 00", bus.pkt_active, bus.frame_err); end
        checks++; if (bus.err_cnt !== 8'h00) begin failures++; $display("FAIL reset_cnt: got %0h want 0", bus.err_cnt); end
        reset = 1'b0;
        tick();
        checks++; if (bus.link_up !== 1'b0 || bus.lane_sel !== 2'd0) begin failures++; $display("FAIL idle_hold: got link=%0b sel=%0h want 0 0", bus.link_up, bus.lane_sel); end
    endtask

    task automatic test_align_run4();
        logic [7:0] exp4 [4];
        exp4 = '{8'h11, 8'h22, 8'h33, 8'h44};
        bus.lane_cfg = 2'd2; bus.enable = 1'b1;
        set_lanes(8'h11, 8'h22, 8'h33, 8'h44, 4'b0000);
        tick();
        checks++; if (bus.link_up !== 1'b0) begin failures++; $display("FAIL align_link: got %0b want 0", bus.link_up); end
        set_lanes(K_COM, K_COM, K_COM, K_COM, 4'b1111);
        tick();
        checks++; if (bus.link_up !== 1'b1 || bus.lane_sel !== 2'd0) begin failures++; $display("FAIL run4_entry: got link=%0b sel=%0h want 1 0", bus.link_up, bus.lane_sel); end
        set_lanes(8'h11, 8'h22, 8'h33, 8'h44, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus.lane_sel !== 2'((i + 1) % 4)) begin failures++; $display("FAIL run4_sel[%0d]: got %0h want %0h", i, bus.lane_sel, (i + 1) % 4); end
            checks++; if (bus.d !== exp4[i % 4] || bus.d_valid !== 1'b1) begin failures++; $display("FAIL run4_d[%0d]: got %0h/%0b want %0h/1", i, bus.d, bus.d_valid, exp4[i % 4]); end
        end
    endtask

    task automatic test_frame2();
        logic [7:0] pb [6];
        bit pk [6], ppkt [6], pdv [6];
        pb = '{K_STP, 8'hAA, K_SKP, 8'h55, K_END, 8'h00};
        pk = '{1, 0, 1, 0, 1, 0};
        ppkt = '{1, 1, 1, 1, 1, 0};
        pdv = '{1, 1, 0, 1, 1, 1};
        bus.enable = 1'b0; tick();
        bus.lane_cfg = 2'd1; bus.enable = 1'b1; tick();
        set_lanes(K_COM, K_COM, 8'h00, 8'h00, 4'b0011);
        tick();
        checks++; if (bus.link_up !== 1'b1) begin failures++; $display("FAIL frame2_link: got %0b want 1", bus.link_up); end
        for (int j = 0; j < 3; j++) begin
            set_lanes(pb[2*j], pb[2*j+1], 8'h00, 8'h00, {2'b00, pk[2*j+1], pk[2*j]});
            for (int h = 0; h < 2; h++) begin
                tick();
                checks++; if (bus.d !== pb[2*j+h] || bus.pkt_active !== ppkt[2*j+h]) begin failures++; $display("FAIL frame2_d_pkt[%0d]: got %0h/%0b want %0h/%0b", 2*j+h, bus.d, bus.pkt_active, pb[2*j+h], ppkt[2*j+h]); end
                checks++; if (bus.d_valid !== pdv[2*j+h] || bus.frame_err !== 1'b0) begin failures++; $display("FAIL frame2_dv_err[%0d]: got %0b/%0b want %0b/0", 2*j+h, bus.d_valid, bus.frame_err, pdv[2*j+h]); end
            end
        end
    endtask

    task automatic test_frame_err();
        set_lanes(K_END, K_STP, 8'h00, 8'h00, 4'b0011);
        tick();
        checks++; if (bus.frame_err !== 1'b1 || bus.pkt_active !== 1'b0) begin failures++; $display("FAIL ferr_end: got %0b/%0b want 1/0", bus.frame_err, bus.pkt_active); end
        tick();
        checks++; if (bus.frame_err !== 1'b0 || bus.pkt_active !== 1'b1) begin failures++; $display("FAIL ferr_open: got %0b/%0b want 0/1", bus.frame_err, bus.pkt_active); end
        set_lanes(K_STP, 8'h00, 8'h00, 8'h00, 4'b0001);
        tick();
        checks++; if (bus.frame_err !== 1'b1 || bus.pkt_active !== 1'b1) begin failures++; $display("FAIL ferr_stp: got %0b/%0b want 1/1", bus.frame_err, bus.pkt_active); end
        tick();
        checks++; if (bus.frame_err !== 1'b0 || bus.err_cnt !== 8'd2) begin failures++; $display("FAIL ferr_cnt: got %0b/%0h want 0/2", bus.frame_err, bus.err_cnt); end
    endtask

    task automatic test_skew();
        bus.enable = 1'b0; tick();
        bus.lane_cfg = 2'd2; bus.enable = 1'b1; tick();
        set_lanes(K_COM, K_COM, K_COM, K_COM, 4'b1111); tick();
        set_lanes(K_STP, 8'h11, 8'h22, 8'h33, 4'b0001);
        repeat (4) tick();
        checks++; if (bus.pkt_active !== 1'b1 || bus.lane_sel !== 2'd0) begin failures++; $display("FAIL skew_pre: got pkt=%0b sel=%0h want 1 0", bus.pkt_active, bus.lane_sel); end
        set_lanes(K_COM, K_COM, 8'h33, 8'h44, 4'b0011);
        tick();
        checks++; if (bus.frame_err !== 1'b1 || bus.link_up !== 1'b0) begin failures++; $display("FAIL skew_hit: got err=%0b link=%0b want 1 0", bus.frame_err, bus.link_up); end
        checks++; if (bus.pkt_active !== 1'b0 || bus.err_cnt !== 8'd3) begin failures++; $display("FAIL skew_clear: got pkt=%0b cnt=%0h want 0 3", bus.pkt_active, bus.err_cnt); end
        tick();
        checks++; if (bus.frame_err !== 1'b0 || bus.link_up !== 1'b0) begin failures++; $display("FAIL skew_align: got err=%0b link=%0b want 0 0", bus.frame_err, bus.link_up); end
    endtask

    task automatic test_saturation();
        bus.enable = 1'b0; tick();
        bus.lane_cfg = 2'd0; bus.enable = 1'b1; tick();
        set_lanes(K_COM, 8'h00, 8'h00, 8'h00, 4'b0001); tick();
        checks++; if (bus.link_up !== 1'b1) begin failures++; $display("FAIL sat_link: got %0b want 1", bus.link_up); end
        set_lanes(8'h00, 8'h00, 8'h00, 8'h00, 4'b0001);
        repeat (300) tick();
        checks++; if (bus.err_cnt !== 8'hFF || bus.frame_err !== 1'b1) begin failures++; $display("FAIL sat_cnt: got %0h/%0b want ff/1", bus.err_cnt, bus.frame_err); end
        checks++; if (bus.lane_sel !== 2'd0) begin failures++; $display("FAIL sat_sel1: got %0h want 0", bus.lane_sel); end
        set_lanes(K_STP, 8'h00, 8'h00, 8'h00, 4'b0001);
        tick();
        checks++; if (bus.pkt_active !== 1'b1) begin failures++; $display("FAIL mid_open: got %0b want 1", bus.pkt_active); end
        reset = 1'b1;
        tick();
        checks++; if (bus.pkt_active !== 1'b0 || bus.link_up !== 1'b0 || bus.frame_err !== 1'b0) begin failures++; $display("FAIL mid_reset: got pkt=%0b link=%0b err=%0b want 0 0 0", bus.pkt_active, bus.link_up, bus.frame_err); end
        checks++; if (bus.err_cnt !== 8'h00 || bus.d !== 8'h00 || bus.lane_sel !== 2'd0) begin failures++; $display("FAIL mid_reset_cnt: got cnt=%0h d=%0h sel=%0h want 0 0 0", bus.err_cnt, bus.d, bus.lane_sel); end
        reset = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] b [4];
        logic k [4];
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 499) == 0);
            bus.enable = ($urandom_range(0, 63) != 0);
            bus.lane_cfg = 2'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                set_lanes(K_COM, K_COM, K_COM, K_COM, 4'b1111);
            end else begin
                for (int i = 0; i < 4; i++) rand_sym(b[i], k[i]);
                set_lanes(b[0], b[1], b[2], b[3], {k[3], k[2], k[1], k[0]});
            end
            tick();
            checks++; if (bus.lane_sel !== 2'(e_sel)) begin failures++; $display("FAIL rnd_sel c%0d: got %0h want %0h", c, bus.lane_sel, e_sel); end
            checks++; if (bus.d !== e_d || bus.dk !== e_dk) begin failures++; $display("FAIL rnd_d c%0d: got %0h/%0b want %0h/%0b", c, bus.d, bus.dk, e_d, e_dk); end
            checks++; if (bus.d_valid !== e_dv) begin failures++; $display("FAIL rnd_dv c%0d: got %0b want %0b", c, bus.d_valid, e_dv); end
            checks++; if (bus.link_up !== e_link) begin failures++; $display("FAIL rnd_link c%0d: got %0b want %0b", c, bus.link_up, e_link); end
            checks++; if (bus.pkt_active !== e_pkt) begin failures++; $display("FAIL rnd_pkt c%0d: got %0b want %0b", c, bus.pkt_active, e_pkt); end
            checks++; if (bus.frame_err !== e_ferr) begin failures++; $display("FAIL rnd_ferr c%0d: got %0b want %0b", c, bus.frame_err, e_ferr); end
            checks++; if (bus.err_cnt !== 8'(e_cnt)) begin failures++; $display("FAIL rnd_cnt c%0d: got %0h want %0h", c, bus.err_cnt, e_cnt); end
        end
        reset = 1'b0;
    endtask

    initial begin
        bus.enable = 1'b0;
        bus.lane_cfg = 2'd0;
        set_lanes(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        test_reset();
        test_align_run4();
        test_frame2();
        test_frame_err();
        test_skew();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
